// File: rtl/reg_scoreboard_file_if.sv
// Bus bundle for the scoreboarded register file: issue port, writeback
// port, and two read ports with per-port busy and sticky error flags.
// There is no valid/ready handshake on this bus. issue_en and wb_en act as
// single-cycle qualifiers and are always accepted. The read ports are purely
// combinational.
interface reg_scoreboard_file_if;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rs_busy;
  logic        rt_busy;
  logic        ovf_err;
  logic        unf_err;

  // Pipeline side: drives issue/writeback/read addresses, observes results.
  modport master (
    output issue_en, issue_addr, wb_en, wb_addr, wb_data, rs_addr, rt_addr,
    input  rs_data, rt_data, rs_busy, rt_busy, ovf_err, unf_err
  );

  // Register file side.
  modport slave (
    input  issue_en, issue_addr, wb_en, wb_addr, wb_data, rs_addr, rt_addr,
    output rs_data, rt_data, rs_busy, rt_busy, ovf_err, unf_err
  );
endinterface

// File: rtl/reg_scoreboard_file.sv
// 32x32 register file with a per-register pending-write counter.
// An issue increments the destination counter and a writeback decrements it.
// A read port reports busy while any write to its register is still in
// flight. The writeback in the current cycle already counts as delivered,
// because its data is bypassed onto the read port in that same cycle.
module reg_scoreboard_file #(
  parameter int CNT_W = 2
) (
  input logic                  clk,
  input logic                  reset,
  reg_scoreboard_file_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      regs [32];
  logic [CNT_W-1:0] cnt  [32];
  logic             ovf_q;
  logic             unf_q;

  // Register 0 is excluded from both data writes and counting.
  logic issue_hit;
  logic wb_hit;
  logic same_reg;

  assign issue_hit = bus.issue_en && (bus.issue_addr != 5'd0);
  assign wb_hit    = bus.wb_en && (bus.wb_addr != 5'd0);
  assign same_reg  = issue_hit && wb_hit && (bus.issue_addr == bus.wb_addr);

  // Storage, counters and sticky error flags. Reset clears them asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wb_hit) begin
        regs[bus.wb_addr] <= bus.wb_data;
      end
      // Issue and writeback to the same register in the same cycle cancel,
      // even at the counter limits, and raise no error.
      if (issue_hit && !same_reg) begin
        if (cnt[bus.issue_addr] == CNT_MAX) begin
          ovf_q <= 1'b1;
        end else begin
          cnt[bus.issue_addr] <= cnt[bus.issue_addr] + 1'b1;
        end
      end
      if (wb_hit && !same_reg) begin
        if (cnt[bus.wb_addr] == '0) begin
          unf_q <= 1'b1;
        end else begin
          cnt[bus.wb_addr] <= cnt[bus.wb_addr] - 1'b1;
        end
      end
    end
  end

  // Read port A: register 0 reads zero. Otherwise the writeback is bypassed,
  // else storage is read. Busy is set if more writes are pending than the
  // one being delivered right now.
  always_comb begin
    logic rs_dec;
    rs_dec      = bus.wb_en && (bus.wb_addr == bus.rs_addr);
    bus.rs_data = '0;
    bus.rs_busy = 1'b0;
    if (bus.rs_addr != 5'd0) begin
      bus.rs_data = rs_dec ? bus.wb_data : regs[bus.rs_addr];
      bus.rs_busy = cnt[bus.rs_addr] > CNT_W'(rs_dec);
    end
  end

  // Read port B: identical rules to port A.
  always_comb begin
    logic rt_dec;
    rt_dec      = bus.wb_en && (bus.wb_addr == bus.rt_addr);
    bus.rt_data = '0;
    bus.rt_busy = 1'b0;
    if (bus.rt_addr != 5'd0) begin
      bus.rt_data = rt_dec ? bus.wb_data : regs[bus.rt_addr];
      bus.rt_busy = cnt[bus.rt_addr] > CNT_W'(rt_dec);
    end
  end

  assign bus.ovf_err = ovf_q;
  assign bus.unf_err = unf_q;

endmodule

// File: tb/tb_reg_scoreboard_file.sv
// Directed bench for reg_scoreboard_file with CNT_W=2.
// Inputs change 1 ns after the rising edge. Outputs are sampled mid-cycle.
module tb_reg_scoreboard_file;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  reg_scoreboard_file_if bus ();

  reg_scoreboard_file #(.CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    bus.issue_en   = 1'b0;
    bus.issue_addr = 5'd0;
    bus.wb_en      = 1'b0;
    bus.wb_addr    = 5'd0;
    bus.wb_data    = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic issue(input logic [4:0] a);
    bus.issue_en   = 1'b1;
    bus.issue_addr = a;
    tick();
    bus.issue_en   = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
    tick();
    bus.wb_en   = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    bus.rs_addr = 5'd5;
    bus.rt_addr = 5'd31;
    #2;
    total++; if (bus.rs_data !== 32'd0) begin bad++; $display("FAIL reset_rs_data got=%h want=0", bus.rs_data); end
    total++; if (bus.rt_data !== 32'd0) begin bad++; $display("FAIL reset_rt_data got=%h want=0", bus.rt_data); end
    total++; if (bus.rs_busy !== 1'b0) begin bad++; $display("FAIL reset_rs_busy got=%b want=0", bus.rs_busy); end
    total++; if (bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b want=00", bus.ovf_err, bus.unf_err); end
  endtask

  task automatic test_wb_bypass();
    do_reset();
    bus.rs_addr = 5'd5;
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd5;
    bus.wb_data = 32'h1234;
    #2;
    total++; if (bus.rs_data !== 32'h1234) begin bad++; $display("FAIL bypass_data got=%h want=1234", bus.rs_data); end
    total++; if (bus.rs_busy !== 1'b0) begin bad++; $display("FAIL bypass_busy got=%b want=0", bus.rs_busy); end
    tick();
    idle();
    #2;
    total++; if (bus.rs_data !== 32'h1234) begin bad++; $display("FAIL stored_data got=%h want=1234", bus.rs_data); end
    total++; if (bus.unf_err !== 1'b1) begin bad++; $display("FAIL wb_unf got=%b want=1", bus.unf_err); end
    total++; if (bus.ovf_err !== 1'b0) begin bad++; $display("FAIL wb_ovf got=%b want=0", bus.ovf_err); end
  endtask

  task automatic test_issue_wb();
    do_reset();
    bus.rt_addr    = 5'd8;
    bus.issue_en   = 1'b1;
    bus.issue_addr = 5'd8;
    #2;
    total++; if (bus.rt_busy !== 1'b0) begin bad++; $display("FAIL issue_same_cycle_busy got=%b want=0", bus.rt_busy); end
    tick();
    idle();
    #2;
    total++; if (bus.rt_busy !== 1'b1) begin bad++; $display("FAIL issue_next_busy got=%b want=1", bus.rt_busy); end
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd8;
    bus.wb_data = 32'hDEADBEEF;
    #2;
    total++; if (bus.rt_busy !== 1'b0) begin bad++; $display("FAIL wb_cycle_busy got=%b want=0", bus.rt_busy); end
    total++; if (bus.rt_data !== 32'hDEADBEEF) begin bad++; $display("FAIL wb_cycle_data got=%h want=deadbeef", bus.rt_data); end
    tick();
    idle();
    #2;
    total++; if (bus.rt_busy !== 1'b0) begin bad++; $display("FAIL after_wb_busy got=%b want=0", bus.rt_busy); end
    total++; if (bus.rt_data !== 32'hDEADBEEF) begin bad++; $display("FAIL after_wb_data got=%h want=deadbeef", bus.rt_data); end
    total++; if (bus.unf_err !== 1'b0) begin bad++; $display("FAIL issue_wb_unf got=%b want=0", bus.unf_err); end
  endtask

  task automatic test_saturate();
    do_reset();
    bus.rs_addr = 5'd3;
    issue(5'd3);
    issue(5'd3);
    issue(5'd3);
    #2;
    total++; if (bus.ovf_err !== 1'b0) begin bad++; $display("FAIL sat_pre_ovf got=%b want=0", bus.ovf_err); end
    issue(5'd3);
    #2;
    total++; if (bus.ovf_err !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b want=1", bus.ovf_err); end
    total++; if (bus.rs_busy !== 1'b1) begin bad++; $display("FAIL sat_busy got=%b want=1", bus.rs_busy); end
    // The count held at 3, so the third writeback is the one that clears busy.
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h11;
    #2;
    total++; if (bus.rs_busy !== 1'b1) begin bad++; $display("FAIL sat_wb1_busy got=%b want=1", bus.rs_busy); end
    tick();
    bus.wb_data = 32'h22;
    #2;
    total++; if (bus.rs_busy !== 1'b1) begin bad++; $display("FAIL sat_wb2_busy got=%b want=1", bus.rs_busy); end
    tick();
    bus.wb_data = 32'h33;
    #2;
    total++; if (bus.rs_busy !== 1'b0) begin bad++; $display("FAIL sat_wb3_busy got=%b want=0", bus.rs_busy); end
    tick();
    idle();
    #2;
    total++; if (bus.rs_busy !== 1'b0) begin bad++; $display("FAIL sat_final_busy got=%b want=0", bus.rs_busy); end
    total++; if (bus.rs_data !== 32'h33) begin bad++; $display("FAIL sat_final_data got=%h want=33", bus.rs_data); end
    total++; if (bus.unf_err !== 1'b0) begin bad++; $display("FAIL sat_unf got=%b want=0", bus.unf_err); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    bus.rs_addr = 5'd7;
    issue(5'd7);
    bus.issue_en = 1'b1; bus.issue_addr = 5'd7;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h77;
    #2;
    total++; if (bus.rs_busy !== 1'b0) begin bad++; $display("FAIL same_busy_now got=%b want=0", bus.rs_busy); end
    total++; if (bus.rs_data !== 32'h77) begin bad++; $display("FAIL same_data_now got=%h want=77", bus.rs_data); end
    tick();
    idle();
    #2;
    total++; if (bus.rs_busy !== 1'b1) begin bad++; $display("FAIL same_busy_next got=%b want=1", bus.rs_busy); end
    total++; if (bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0) begin bad++; $display("FAIL same_err got=%b%b want=00", bus.ovf_err, bus.unf_err); end
    // With the count at zero, issue and writeback together must not flag underflow.
    do_reset();
    bus.issue_en = 1'b1; bus.issue_addr = 5'd7;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h70;
    tick();
    idle();
    #2;
    total++; if (bus.rs_busy !== 1'b0) begin bad++; $display("FAIL same_zero_busy got=%b want=0", bus.rs_busy); end
    total++; if (bus.unf_err !== 1'b0) begin bad++; $display("FAIL same_zero_unf got=%b want=0", bus.unf_err); end
    total++; if (bus.rs_data !== 32'h70) begin bad++; $display("FAIL same_zero_data got=%h want=70", bus.rs_data); end
  endtask

  task automatic test_reg0();
    do_reset();
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFFFFFF;
    bus.issue_en = 1'b1; bus.issue_addr = 5'd0;
    #2;
    total++; if (bus.rs_data !== 32'd0) begin bad++; $display("FAIL r0_data_now got=%h want=0", bus.rs_data); end
    total++; if (bus.rs_busy !== 1'b0) begin bad++; $display("FAIL r0_busy_now got=%b want=0", bus.rs_busy); end
    tick();
    idle();
    #2;
    total++; if (bus.rt_data !== 32'd0) begin bad++; $display("FAIL r0_data_next got=%h want=0", bus.rt_data); end
    total++; if (bus.rt_busy !== 1'b0) begin bad++; $display("FAIL r0_busy_next got=%b want=0", bus.rt_busy); end
    total++; if (bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0) begin bad++; $display("FAIL r0_err got=%b%b want=00", bus.ovf_err, bus.unf_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.rs_addr = 5'd9;
    wb(5'd9, 32'hABCD);
    issue(5'd9);
    issue(5'd9);
    #2;
    total++; if (bus.rs_busy !== 1'b1) begin bad++; $display("FAIL ar_pre_busy got=%b want=1", bus.rs_busy); end
    total++; if (bus.rs_data !== 32'hABCD) begin bad++; $display("FAIL ar_pre_data got=%h want=abcd", bus.rs_data); end
    // Assert reset mid-cycle, away from any clock edge.
    reset = 1'b1;
    #1;
    total++; if (bus.rs_busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b want=0", bus.rs_busy); end
    total++; if (bus.rs_data !== 32'd0) begin bad++; $display("FAIL ar_data got=%h want=0", bus.rs_data); end
    total++; if (bus.unf_err !== 1'b0) begin bad++; $display("FAIL ar_unf got=%b want=0", bus.unf_err); end
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h55;
    #1;
    total++; if (bus.rs_data !== 32'h55) begin bad++; $display("FAIL ar_bypass got=%h want=55", bus.rs_data); end
    total++; if (bus.rs_busy !== 1'b0) begin bad++; $display("FAIL ar_bypass_busy got=%b want=0", bus.rs_busy); end
    idle();
    tick();
    reset = 1'b0;
    #2;
    total++; if (bus.rs_data !== 32'd0) begin bad++; $display("FAIL ar_release_data got=%h want=0", bus.rs_data); end
    wb(5'd9, 32'h99);
    #2;
    total++; if (bus.unf_err !== 1'b1) begin bad++; $display("FAIL ar_post_unf got=%b want=1", bus.unf_err); end
    total++; if (bus.rs_data !== 32'h99) begin bad++; $display("FAIL ar_post_data got=%h want=99", bus.rs_data); end
  endtask

  task automatic test_dual_port();
    do_reset();
    wb(5'd4, 32'hA4A4A4A4);
    wb(5'd6, 32'hB6B6B6B6);
    issue(5'd6);
    bus.rs_addr = 5'd4;
    bus.rt_addr = 5'd6;
    #2;
    total++; if (bus.rs_data !== 32'hA4A4A4A4) begin bad++; $display("FAIL dp_rs_data got=%h want=a4a4a4a4", bus.rs_data); end
    total++; if (bus.rs_busy !== 1'b0) begin bad++; $display("FAIL dp_rs_busy got=%b want=0", bus.rs_busy); end
    total++; if (bus.rt_data !== 32'hB6B6B6B6) begin bad++; $display("FAIL dp_rt_data got=%h want=b6b6b6b6", bus.rt_data); end
    total++; if (bus.rt_busy !== 1'b1) begin bad++; $display("FAIL dp_rt_busy got=%b want=1", bus.rt_busy); end
    bus.rs_addr = 5'd6;
    #1;
    total++; if (bus.rs_data !== 32'hB6B6B6B6) begin bad++; $display("FAIL dp_same_data got=%h want=b6b6b6b6", bus.rs_data); end
    total++; if (bus.rs_busy !== 1'b1) begin bad++; $display("FAIL dp_same_busy got=%b want=1", bus.rs_busy); end
  endtask

  // Sequence and final report
  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle();
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    test_reset();
    test_wb_bypass();
    test_issue_wb();
    test_saturate();
    test_same_cycle();
    test_reg0();
    test_async_reset();
    test_dual_port();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard_file.md
REG_SCOREBOARD_FILE -- requirements
Module: reg_scoreboard_file

Interface
REQ-001 The block SHALL expose parameter CNT_W, default 2, meaning width of each per-register pending-write counter (max in-flight writes = 2^CNT_W-1).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Ports, in order:
 clk  input  1  rising-edge clock
 reset  input  1  asynchronous active-high reset
 issue_en  input  1  D-stage instruction with reg_write=1 leaves D this cycle
 issue_addr  input  5  its destination register
 wb_en  input  1  W-stage reg_write
 wb_addr  input  5  W-stage reg_addr
 wb_data  input  32  W-stage selected writeback data
 rs_addr  input  5  read port A address
 rt_addr  input  5  read port B address
 rs_data  output  32  read port A data
 rt_data  output  32  read port B data
 rs_busy  output  1  port A value not yet available
 rt_busy  output  1  port B value not yet available
 ovf_err  output  1  sticky: issue on saturated counter
 unf_err  output  1  sticky: writeback on zero counter

Function
REQ-004 Storage SHALL be 32 x 32-bit registers plus 32 counters of CNT_W bits; register 0 SHALL read 0 and never change.
REQ-005 On rising clk with wb_en=1 and wb_addr!=0, reg[wb_addr] SHALL take wb_data; wb_en=1 with wb_addr=0 SHALL change nothing.
REQ-006 rs_data SHALL be combinational: 0 if rs_addr=0; else wb_data if wb_en=1 and wb_addr=rs_addr; else reg[rs_addr] (write-through bypass, same-cycle visibility); rt_data likewise.
REQ-007 Counter update per register r!=0 on rising clk: inc = issue_en & issue_addr=r; dec = wb_en & wb_addr=r; next = cnt+inc-dec.
REQ-008 inc and dec on the same register in the same cycle SHALL leave cnt unchanged, including when cnt=0 or saturated, with no error flag.
REQ-009 inc alone at cnt=2^CNT_W-1 SHALL hold cnt and set ovf_err.
REQ-010 dec alone at cnt=0 SHALL hold cnt at 0, still perform the data write, and set unf_err.
REQ-011 Address 0 SHALL never be counted; issue or writeback to register 0 SHALL not touch counters or error flags.
REQ-012 rs_busy SHALL be 0 if rs_addr=0; else 1 iff cnt[rs_addr] minus (wb_en & wb_addr=rs_addr) is nonzero; issue_en in the same cycle SHALL not affect busy; rt_busy likewise.
REQ-013 Latency: write visible on read port same cycle via bypass, from storage from next cycle; issue makes busy 1 from next cycle.
REQ-014 ovf_err and unf_err SHALL stay 1 once set until reset.
REQ-015 rs and rt ports SHALL be independent; rs_addr=rt_addr SHALL return identical data and busy.

Reset
REQ-016 reset=1 SHALL immediately clear all 32 registers, all counters, ovf_err and unf_err, independent of clk.
REQ-017 During reset, rs_data/rt_data SHALL reflect cleared storage, except the REQ-006 bypass stays combinational (wb_data visible for nonzero wb_addr); rs_busy/rt_busy SHALL be 0.
REQ-018 Reset asserted mid-operation SHALL discard all pending counts; wb after deassertion SHALL set unf_err per REQ-010.

Verification
REQ-019 Reset, wb_en=1 wb_addr=5 wb_data=0x1234 one cycle, then rs_addr=5 -> rs_data=0x1234 same cycle (bypass) and after the edge; unf_err=1.
REQ-020 issue_en=1 issue_addr=8; next cycle rt_addr=8 -> rt_busy=1; cycle with wb_en=1 wb_addr=8 wb_data=0xDEADBEEF -> rt_busy=0, rt_data=0xDEADBEEF that cycle.
REQ-021 Three issues to reg 3 (cnt=3, CNT_W=2) then fourth issue -> cnt holds 3, ovf_err=1; three writebacks -> rs_busy falls during the third writeback cycle.
REQ-022 Same cycle issue_addr=7 and wb_addr=7 with cnt=1 -> cnt stays 1, rs_busy(7)=0 that cycle, 1 next cycle, no error flags.
REQ-023 wb_en=1 wb_addr=0 wb_data=0xFFFFFFFF; issue_addr=0 -> rs_addr=0 gives 0, busy 0, no error flags.
REQ-024 Two issues to reg 9, reset asserted asynchronously between clk edges -> rs_busy(9)=0 and rs_data=0 immediately; wb to 9 after release -> unf_err=1.
